// File: rtl/kb_tx_pkg.sv
// Shared constants for the PS/2 host transmitter: FSM encoding, register map,
// STATUS bit positions and the clock divisors for the 100 us / 20 ms intervals.
package kb_tx_pkg;

  localparam logic [2:0] ST_IDLE    = 3'd0;
  localparam logic [2:0] ST_INHIBIT = 3'd1;
  localparam logic [2:0] ST_START   = 3'd2;
  localparam logic [2:0] ST_SHIFT   = 3'd3;
  localparam logic [2:0] ST_ACK     = 3'd4;

  // Values of adr_i[2]
  localparam logic REG_TXDATA = 1'b0;
  localparam logic REG_STATUS = 1'b1;

  localparam int STAT_BUSY    = 0;
  localparam int STAT_DONE    = 1;
  localparam int STAT_NOACK   = 2;
  localparam int STAT_TIMEOUT = 3;
  localparam int STAT_OVR     = 4;
  localparam int STAT_IRQ_EN  = 8;

  // CLOCK_FREQ / DIV_100US = cycles in 100 us, CLOCK_FREQ / DIV_20MS = cycles in 20 ms
  localparam int DIV_100US = 10000;
  localparam int DIV_20MS  = 50;

  function automatic logic odd_parity(input logic [7:0] d);
    return ~^d;
  endfunction

endpackage

// File: rtl/kb_sync2.sv
// Two-flop synchronizer for an idle-high PS/2 line; resets to 1 (released line).
module kb_sync2 (
  input  logic clk_i,
  input  logic rst_i,
  input  logic d_i,
  output logic q_o
);

  logic meta;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      meta <= 1'b1;
      q_o  <= 1'b1;
    end else begin
      meta <= d_i;
      q_o  <= meta;
    end
  end

endmodule

// File: rtl/kb_tx.sv
// PS/2 host-to-device transmitter with a small Wishbone-style register interface.
// Software writes a byte to TXDATA; STATUS reports busy/done/noack/timeout/overrun.
module kb_tx
  import kb_tx_pkg::*;
#(
  parameter int CLOCK_FREQ = 50000000
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        cyc_i,
  input  logic        stb_i,
  input  logic        we_i,
  input  logic [3:0]  sel_i,
  input  logic [31:0] adr_i,
  input  logic [31:0] dat_i,
  output logic [31:0] dat_o,
  output logic        ack_o,
  output logic        int_o,
  input  logic        kb_clk_i,
  input  logic        kb_dat_i,
  output logic        kb_clk_oe_o,
  output logic        kb_dat_oe_o
);

  localparam int INHIBIT_CYCLES = CLOCK_FREQ / DIV_100US;
  localparam int TIMEOUT_CYCLES = CLOCK_FREQ / DIV_20MS;
  localparam int CNT_W          = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CNT_W-1:0] INH_LAST = CNT_W'(INHIBIT_CYCLES - 1);
  localparam logic [CNT_W-1:0] TO_LAST  = CNT_W'(TIMEOUT_CYCLES - 1);

  logic [2:0]       state;
  logic [CNT_W-1:0] cnt;
  logic [7:0]       tx_data;
  logic             tx_par;
  logic [3:0]       bit_cnt;
  logic             shift_oe;
  logic             done, noack, timeout, ovr, irq_en;
  logic             clk_s, dat_s, clk_s_d;
  logic [31:0]      status_word;

  kb_sync2 u_sync_clk (.clk_i(clk_i), .rst_i(rst_i), .d_i(kb_clk_i), .q_o(clk_s));
  kb_sync2 u_sync_dat (.clk_i(clk_i), .rst_i(rst_i), .d_i(kb_dat_i), .q_o(dat_s));

  // Handshake: a request is cyc_i & stb_i while ack_o is low; it is serviced in the
  // cycle it is seen, and ack_o answers the following cycle for exactly one cycle
  // with dat_o valid only during that ack (0 otherwise).
  logic req, wr_tx, wr_st, w1c, busy, start_tx, kb_fall, in_frame;
  logic set_done, set_noack, set_timeout, set_ovr, ack_edge;

  assign req      = cyc_i & stb_i & ~ack_o;
  assign wr_tx    = req & we_i & (adr_i[2] == REG_TXDATA) & sel_i[0];
  assign wr_st    = req & we_i & (adr_i[2] == REG_STATUS);
  assign w1c      = wr_st & sel_i[0];
  assign busy     = (state != ST_IDLE);
  assign start_tx = wr_tx & ~busy;
  assign set_ovr  = wr_tx & busy;
  assign kb_fall  = clk_s_d & ~clk_s;
  assign in_frame = (state == ST_START) | (state == ST_SHIFT) | (state == ST_ACK);

  // A final ack edge landing on the timeout cycle still counts as a completed frame.
  assign ack_edge    = (state == ST_ACK) & kb_fall;
  assign set_done    = ack_edge & ~dat_s;
  assign set_noack   = ack_edge & dat_s;
  assign set_timeout = in_frame & (cnt == TO_LAST) & ~ack_edge;

  always_comb begin
    status_word               = '0;
    status_word[STAT_BUSY]    = busy;
    status_word[STAT_DONE]    = done;
    status_word[STAT_NOACK]   = noack;
    status_word[STAT_TIMEOUT] = timeout;
    status_word[STAT_OVR]     = ovr;
    status_word[STAT_IRQ_EN]  = irq_en;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      ack_o    <= 1'b0;
      dat_o    <= '0;
      done     <= 1'b0;
      noack    <= 1'b0;
      timeout  <= 1'b0;
      ovr      <= 1'b0;
      irq_en   <= 1'b0;
      clk_s_d  <= 1'b1;
      state    <= ST_IDLE;
      cnt      <= '0;
      tx_data  <= '0;
      tx_par   <= 1'b0;
      bit_cnt  <= '0;
      shift_oe <= 1'b0;
    end else begin
      ack_o   <= req;
      dat_o   <= (req & ~we_i & (adr_i[2] == REG_STATUS)) ? status_word : '0;
      clk_s_d <= clk_s;

      // Hardware set wins over a simultaneous write-1-to-clear.
      done    <= (done    & ~(w1c & dat_i[STAT_DONE]))    | set_done;
      noack   <= (noack   & ~(w1c & dat_i[STAT_NOACK]))   | set_noack;
      timeout <= (timeout & ~(w1c & dat_i[STAT_TIMEOUT])) | set_timeout;
      ovr     <= (ovr     & ~(w1c & dat_i[STAT_OVR]))     | set_ovr;
      if (wr_st && sel_i[1]) irq_en <= dat_i[STAT_IRQ_EN];

      case (state)
        ST_IDLE: begin
          if (start_tx) begin
            tx_data <= dat_i[7:0];
            tx_par  <= odd_parity(dat_i[7:0]);
            cnt     <= '0;
            state   <= ST_INHIBIT;
          end
        end
        ST_INHIBIT: begin
          if (cnt == INH_LAST) begin
            cnt   <= '0;
            state <= ST_START;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        ST_START, ST_SHIFT, ST_ACK: begin
          cnt <= cnt + 1'b1;
          if (set_timeout) begin
            shift_oe <= 1'b0;
            state    <= ST_IDLE;
          end else if (kb_fall) begin
            if (state == ST_START) begin
              shift_oe <= ~tx_data[0];
              bit_cnt  <= 4'd1;
              state    <= ST_SHIFT;
            end else if (state == ST_SHIFT) begin
              bit_cnt <= bit_cnt + 1'b1;
              if (bit_cnt < 4'd8) begin
                shift_oe <= ~tx_data[bit_cnt[2:0]];
              end else if (bit_cnt == 4'd8) begin
                shift_oe <= ~tx_par;
              end else begin
                shift_oe <= 1'b0;
                state    <= ST_ACK;
              end
            end else begin
              state <= ST_IDLE;
            end
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  // Open-drain controls decode straight from state, so a reset releases the lines
  // in the very next cycle.
  assign kb_clk_oe_o = (state == ST_INHIBIT);
  assign kb_dat_oe_o = ((state == ST_INHIBIT) && (cnt == INH_LAST)) ||
                       (state == ST_START) ||
                       ((state == ST_SHIFT) && shift_oe);
  assign int_o = irq_en & (done | noack | timeout | ovr);

  logic unused_bits;
  assign unused_bits = ^{adr_i[31:3], adr_i[1:0], sel_i[3:2], dat_i[31:9]};

endmodule

// File: tb/tb_kb_tx.sv
// Self-checking bench for kb_tx: register vector table, then a 12 kHz-equivalent
// PS/2 device model exercising full frames, timeout, noack, overrun and reset.
module tb_kb_tx;

  // Clock scaled 1/100 so the run stays short; all timings derive from CLK_FREQ
  // (INH = 5000 and TO = 1000000 cycles at 50 MHz become 50 and 10000 here).
  localparam int CLK_FREQ = 500_000;
  localparam int INH      = CLK_FREQ / 10000;
  localparam int TO       = CLK_FREQ / 50;
  localparam int HALF     = 21;  // 42-cycle period = ~12 kHz device clock at this scale

  logic        clk = 1'b0;
  logic        rst_i = 1'b1;
  logic        cyc = 1'b0, stb = 1'b0, we = 1'b0;
  logic [3:0]  sel = 4'h0;
  logic [31:0] adr = '0, wdat = '0;
  logic [31:0] dat_o;
  logic        ack_o, int_o, kb_clk_oe_o, kb_dat_oe_o;
  logic        dev_clk = 1'b1, dev_dat = 1'b1;
  logic        kb_clk_i, kb_dat_i;

  assign kb_clk_i = dev_clk & ~kb_clk_oe_o;
  assign kb_dat_i = dev_dat & ~kb_dat_oe_o;

  kb_tx #(.CLOCK_FREQ(CLK_FREQ)) dut (
    .clk_i(clk), .rst_i(rst_i), .cyc_i(cyc), .stb_i(stb), .we_i(we), .sel_i(sel),
    .adr_i(adr), .dat_i(wdat), .dat_o(dat_o), .ack_o(ack_o), .int_o(int_o),
    .kb_clk_i(kb_clk_i), .kb_dat_i(kb_dat_i),
    .kb_clk_oe_o(kb_clk_oe_o), .kb_dat_oe_o(kb_dat_oe_o)
  );

  // ---------------- clock / watchdog ----------------
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected $finish");
    $fatal(1, "watchdog");
  end

  // ---------------- scoreboard ----------------
  int n_pass = 0;
  int n_total = 0;
  logic [9:0] exp_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  // Inhibit monitor: length of each clk-low run, and where data was pulled inside it.
  int inh_run = 0, inh_len = 0, inh_dat_cnt = 0, inh_dat = 0;
  logic inh_last_dat = 1'b0, inh_last = 1'b0;
  always @(negedge clk) begin
    if (kb_clk_oe_o) begin
      if (inh_run == 0) inh_dat_cnt = 0;
      inh_run++;
      if (kb_dat_oe_o) inh_dat_cnt++;
      inh_last_dat = kb_dat_oe_o;
    end else if (inh_run != 0) begin
      inh_len  = inh_run;
      inh_dat  = inh_dat_cnt;
      inh_last = inh_last_dat;
      inh_run  = 0;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic bus_xfer(input logic w, input logic adr2, input logic [3:0] s,
                          input logic [31:0] d, output logic [31:0] rd);
    @(negedge clk);
    cyc = 1'b1; stb = 1'b1; we = w; sel = s; wdat = d;
    adr = {29'h0, adr2, 2'b00};
    @(negedge clk);
    check("ack_high", ack_o, 1);
    rd = dat_o;
    cyc = 1'b0; stb = 1'b0; we = 1'b0;
    @(negedge clk);
    check("ack_single", ack_o, 0);
    check("dat_idle", dat_o, 0);
  endtask

  task automatic rd_status(input string name, input logic [31:0] exp);
    logic [31:0] rd;
    bus_xfer(1'b0, 1'b1, 4'hf, 32'h0, rd);
    check(name, rd, exp);
  endtask

  task automatic wr_reg(input logic adr2, input logic [3:0] s, input logic [31:0] d);
    logic [31:0] rd;
    bus_xfer(1'b1, adr2, s, d, rd);
  endtask

  task automatic dev_wait_start(output bit ok);
    int t = 0;
    while (!kb_clk_oe_o && t < 200) begin @(negedge clk); t++; end
    while (kb_clk_oe_o && t < INH + 400) begin @(negedge clk); t++; end
    ok = !kb_clk_oe_o && (t < INH + 400);
  endtask

  task automatic dev_clock(input int n_edges, input bit do_ack, output logic [10:0] bits);
    bits = '1;
    repeat (8) @(negedge clk);
    bits[0] = kb_dat_i;
    for (int k = 1; k <= n_edges; k++) begin
      if (k == 11) begin
        if (do_ack) dev_dat = 1'b0;
        repeat (4) @(negedge clk);
      end
      dev_clk = 1'b0;
      repeat (HALF) @(negedge clk);
      dev_clk = 1'b1;
      if (k <= 10) bits[k] = kb_dat_i;
      repeat (HALF) @(negedge clk);
      if (k == 11) dev_dat = 1'b1;
    end
  endtask

  task automatic start_tx(input logic [7:0] b, input logic [9:0] exp_bits);
    exp_q.push_back(exp_bits);
    wr_reg(1'b0, 4'h1, {24'h0, b});
  endtask

  task automatic finish_frame(input bit do_ack);
    bit ok;
    logic [10:0] bits;
    logic [9:0] exp;
    dev_wait_start(ok);
    check("start_seen", ok, 1);
    check("start_dat_oe", kb_dat_oe_o, 1);
    dev_clock(11, do_ack, bits);
    check("start_bit", bits[0], 0);
    exp = (exp_q.size() != 0) ? exp_q.pop_front() : 10'h0;
    check("frame_bits", bits[10:1], exp);
    check("inhibit_len", inh_len, INH);
    check("inhibit_dat_cycles", inh_dat, 1);
    check("inhibit_dat_last", inh_last, 1);
    repeat (5) @(negedge clk);
  endtask

  // ---------------- register vector table ----------------
  typedef struct {
    logic        w;
    logic        adr2;
    logic [3:0]  s;
    logic [31:0] d;
    logic [31:0] exp_rd;
    logic        exp_int;
    string       name;
  } vec_t;

  vec_t vecs[8];

  initial begin
    logic [31:0] rd;
    bit ok;
    logic [10:0] bits;
    int t;

    vecs[0] = '{1'b0, 1'b1, 4'hf, 32'h0,   32'h0,   1'b0, "rst_status"};
    vecs[1] = '{1'b0, 1'b0, 4'hf, 32'h0,   32'h0,   1'b0, "txdata_reads_0"};
    vecs[2] = '{1'b1, 1'b1, 4'h1, 32'h100, 32'h0,   1'b0, "irq_en_no_sel1"};
    vecs[3] = '{1'b0, 1'b1, 4'hf, 32'h0,   32'h0,   1'b0, "status_after_sel0"};
    vecs[4] = '{1'b1, 1'b1, 4'h3, 32'h11e, 32'h0,   1'b0, "irq_en_set"};
    vecs[5] = '{1'b0, 1'b1, 4'hf, 32'h0,   32'h100, 1'b0, "status_irq_en"};
    vecs[6] = '{1'b1, 1'b0, 4'he, 32'haa,  32'h0,   1'b0, "txdata_no_sel0"};
    vecs[7] = '{1'b0, 1'b1, 4'hf, 32'h0,   32'h100, 1'b0, "status_not_busy"};

    // reset
    rst_i = 1'b1;
    repeat (3) @(negedge clk);
    rst_i = 1'b0;
    @(negedge clk);
    check("rst_ack", ack_o, 0);
    check("rst_dat", dat_o, 0);
    check("rst_int", int_o, 0);
    check("rst_clk_oe", kb_clk_oe_o, 0);
    check("rst_dat_oe", kb_dat_oe_o, 0);

    for (int i = 0; i < 8; i++) begin
      bus_xfer(vecs[i].w, vecs[i].adr2, vecs[i].s, vecs[i].d, rd);
      if (!vecs[i].w) check(vecs[i].name, rd, vecs[i].exp_rd);
      check("vec_int", int_o, vecs[i].exp_int);
    end
    check("vec_lines_idle", kb_clk_oe_o, 0);

    // 0xED: parity 1, stop 1, device acks
    start_tx(8'hed, 10'h3ed);
    finish_frame(1'b1);
    rd_status("ed_status", 32'h102);
    check("ed_int", int_o, 1);
    wr_reg(1'b1, 4'h2, 32'h102);
    rd_status("w1c_needs_sel0", 32'h102);
    wr_reg(1'b1, 4'h3, 32'h102);
    rd_status("done_cleared", 32'h100);
    check("int_cleared", int_o, 0);

    // 0x00: parity bit must be 1
    start_tx(8'h00, 10'h300);
    finish_frame(1'b1);
    rd_status("zero_status", 32'h102);
    wr_reg(1'b1, 4'h1, 32'h2);

    // device never clocks
    wr_reg(1'b0, 4'h1, 32'h55);
    dev_wait_start(ok);
    check("to_start_seen", ok, 1);
    t = 0;
    while (kb_dat_oe_o && t < TO + 100) begin t++; @(negedge clk); end
    check("timeout_cycles", t, TO);
    check("to_clk_oe", kb_clk_oe_o, 0);
    check("to_dat_oe", kb_dat_oe_o, 0);
    rd_status("to_status", 32'h108);
    check("to_int", int_o, 1);
    wr_reg(1'b1, 4'h1, 32'h8);

    // device omits ack; 0x07 has odd parity 0
    start_tx(8'h07, 10'h207);
    finish_frame(1'b0);
    rd_status("noack_status", 32'h104);
    check("noack_int", int_o, 1);
    wr_reg(1'b1, 4'h1, 32'h4);

    // overrun: second write during the frame is dropped
    start_tx(8'ha5, 10'h3a5);
    wr_reg(1'b0, 4'h1, 32'h5a);
    rd_status("ovr_busy_status", 32'h111);
    finish_frame(1'b1);
    rd_status("ovr_done_status", 32'h112);
    wr_reg(1'b1, 4'h1, 32'h10);
    rd_status("ovr_cleared", 32'h102);
    wr_reg(1'b1, 4'h1, 32'h2);
    rd_status("all_cleared", 32'h100);

    // reset during SHIFT bit 4 (0xED bit 4 = 0 -> data pulled)
    wr_reg(1'b0, 4'h1, 32'hed);
    dev_wait_start(ok);
    check("rst_frame_start", ok, 1);
    dev_clock(5, 1'b0, bits);
    check("bit4_line", bits[5], 0);
    check("bit4_dat_oe", kb_dat_oe_o, 1);
    rst_i = 1'b1;
    @(negedge clk);
    check("midrst_clk_oe", kb_clk_oe_o, 0);
    check("midrst_dat_oe", kb_dat_oe_o, 0);
    rst_i = 1'b0;
    @(negedge clk);
    rd_status("midrst_status", 32'h0);
    check("midrst_int", int_o, 0);

    // clean frame after reset; irq_en now 0
    start_tx(8'h12, 10'h312);
    finish_frame(1'b1);
    rd_status("post_rst_status", 32'h002);
    check("post_rst_int", int_o, 0);
    check("exp_q_empty", exp_q.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/kb_tx.md
KB_TX -- requirements
Module: kb_tx

Interface
REQ-001 SHALL have parameter CLOCK_FREQ, default 50000000, meaning the clk_i frequency in Hz.
REQ-002 SHALL derive INHIBIT_CYCLES = CLOCK_FREQ/10000 (100 us) and TIMEOUT_CYCLES = CLOCK_FREQ/50 (20 ms) as localparams.
REQ-003 SHALL use one clock and a synchronous, active-high reset.
REQ-004 Ports:
- clk_i  in  1  system clock.
- rst_i  in  1  synchronous active-high reset.
- cyc_i  in  1  bus cycle.
- stb_i  in  1  strobe.
- we_i  in  1  write enable.
- sel_i  in  4  byte selects.
- adr_i  in  32  address; only adr_i[2] decoded.
- dat_i  in  32  write data.
- dat_o  out  32  read data.
- ack_o  out  1  transfer acknowledge.
- int_o  out  1  interrupt request, level.
- kb_clk_i  in  1  PS/2 clock line sensed.
- kb_dat_i  in  1  PS/2 data line sensed.
- kb_clk_oe_o  out  1  1 = pull PS/2 clock low.
- kb_dat_oe_o  out  1  1 = pull PS/2 data low.

Function
REQ-005 Bus handshake: a request is cyc_i&stb_i&!ack_o; ack_o SHALL assert one cycle after the request for exactly one cycle; dat_o SHALL be valid while ack_o=1 and 0 otherwise.
REQ-006 Register map: adr_i[2]=0 is TXDATA (write-only, reads 0); adr_i[2]=1 is STATUS.
REQ-007 STATUS bits:
- [0] busy (RO).
- [1] done.
- [2] noack.
- [3] timeout.
- [4] ovr.
- [8] irq_en (RW).
- Bits 1-4 are write-1-to-clear, applied only when sel_i[0]; irq_en is written only when sel_i[1]; unused bits read 0.
REQ-008 A TXDATA write with sel_i[0]=1 while idle SHALL latch dat_i[7:0], compute odd parity, and enter INHIBIT.
- If busy, the write SHALL be dropped and ovr set.
- With sel_i[0]=0 the write SHALL be ignored.
REQ-009 kb_clk_i and kb_dat_i SHALL each pass through a 2-flop synchronizer; a device falling edge is synced clock 1 then 0 on consecutive cycles.
REQ-010 FSM states: IDLE, INHIBIT, START, SHIFT, ACK.
- IDLE: both oe=0.
- INHIBIT: kb_clk_oe_o=1; kb_dat_oe_o=1 asserted in the last cycle; lasts INHIBIT_CYCLES cycles, then goes to START.
- START: kb_clk_oe_o=0, kb_dat_oe_o=1 (start bit 0); waits for the first falling edge, then goes to SHIFT.
REQ-011 SHIFT sequence:
- On falling edges 1..8, kb_dat_oe_o SHALL equal the inverse of data bit 0..7, LSB first.
- Falling edge 9 drives parity.
- Falling edge 10 SHALL set kb_dat_oe_o=0 (stop bit) and go to ACK.
- Each oe update SHALL take effect in the cycle after the edge is detected.
REQ-012 ACK: at the next falling edge, synced data 0 SHALL set done; 1 SHALL set noack; then return to IDLE.
REQ-013 A frame timeout counter SHALL start on entry to START. If it reaches TIMEOUT_CYCLES before ACK completes:
- set timeout;
- release both lines next cycle;
- go to IDLE.
REQ-014 busy SHALL be 1 in every state except IDLE.
REQ-015 int_o = irq_en & (done|noack|timeout|ovr).
REQ-016 If a W1C and a hardware set of the same bit occur in the same cycle, the set SHALL win.
REQ-017 Falling edges in IDLE SHALL be ignored; device-initiated traffic belongs to the receiver.

Reset
REQ-018 On rst_i, regardless of state:
- FSM goes to IDLE.
- ack_o=0, dat_o=0, int_o=0.
- kb_clk_oe_o=0, kb_dat_oe_o=0.
- All STATUS bits, irq_en, counters, shift register and synchronizers are cleared (synchronizers to 1).
- Lines SHALL be released in the cycle after rst_i is sampled, even mid-frame.

Structure
REQ-019 A shared package SHALL hold the FSM state encoding, register offsets, STATUS bit indices and the 100 us / 20 ms divisors.
REQ-020 A single sub-module kb_sync2 (2-flop synchronizer with reset value 1) SHALL be instantiated twice; everything else is flat.

Verification
REQ-021 The bench SHALL use a PS/2 device model with a 12 kHz clock, CLOCK_FREQ=50000000, and cover:
- Write TXDATA=0xED while idle: kb_clk_oe_o low for 5000 cycles; device receives 0xED with parity 1 and stop 1; device acks; then STATUS reads 0x002, int_o=1 if irq_en.
- Write TXDATA=0x00: parity bit driven 1; done set.
- Device never clocks: timeout set 1000000 cycles after START entry; both oe=0; busy=0.
- Device omits the ack (data high at the 11th edge): noack set, done clear.
- Second TXDATA write during a frame: ovr set; the first byte still completes unchanged; W1C of 0x10 clears ovr.
- rst_i pulsed during SHIFT bit 4: both oe=0 the next cycle; STATUS reads 0; a new write starts a clean frame.
